// File: rtl/soc_event_arb_fifo.sv
// Arbitrated multi-source event collector that feeds a FIFO with a first-word-fall-through head.
// Sources follow a valid/ack protocol; the drain side follows a valid/ready protocol.
module soc_event_arb_fifo #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned EVNT_WIDTH  = 8,
  parameter int unsigned LOG_DEPTH   = 3,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned AFULL_TH    = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic [N_CH-1:0]              evt_valid_i,
  input  logic [N_CH*EVNT_WIDTH-1:0]   evt_data_i,
  output logic [N_CH-1:0]              evt_ack_o,
  output logic                         evt_valid_o,
  output logic [EVNT_WIDTH-1:0]        evt_data_o,
  input  logic                         evt_ready_i,
  output logic [LOG_DEPTH:0]           fill_o,
  output logic                         almost_full_o,
  output logic                         full_o
);

  localparam int unsigned Depth = 2 ** LOG_DEPTH;
  localparam int unsigned RrW   = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [EVNT_WIDTH-1:0] r_mem [Depth];
  logic [LOG_DEPTH-1:0]  r_wptr;
  logic [LOG_DEPTH-1:0]  r_rptr;
  logic [LOG_DEPTH:0]    r_fill;
  logic [RrW-1:0]        r_rr_ptr;

  logic [RrW-1:0]        w_grant;
  logic [RrW-1:0]        w_rr_nxt;
  logic [EVNT_WIDTH-1:0] w_grant_data;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;

  assign w_full = (r_fill == (LOG_DEPTH+1)'(Depth));

  // First pass honours the round-robin pointer, second pass wraps to the lowest requester.
  always_comb begin
    logic found;
    found   = 1'b0;
    w_grant = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!found && evt_valid_i[i] && (ROUND_ROBIN == 0 || i >= int'(r_rr_ptr))) begin
        w_grant = RrW'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!found && evt_valid_i[i]) begin
        w_grant = RrW'(i);
        found   = 1'b1;
      end
    end
  end

  // Reset gates the push so acks read 0 while reset is held.
  assign w_push       = (|evt_valid_i) & ~w_full & ~clear_i & rst_ni;
  assign w_pop        = evt_valid_o & evt_ready_i;
  assign w_grant_data = evt_data_i[w_grant*EVNT_WIDTH +: EVNT_WIDTH];

  always_comb begin
    evt_ack_o = '0;
    if (w_push) begin
      evt_ack_o[w_grant] = 1'b1;
    end
  end

  always_comb begin
    w_rr_nxt = '0;
    if (N_CH > 1 && ROUND_ROBIN != 0) begin
      w_rr_nxt = (int'(w_grant) == int'(N_CH) - 1) ? '0 : w_grant + RrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fill   <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (clear_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fill   <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_grant_data;
        r_wptr        <= r_wptr + 1'b1;
        r_rr_ptr      <= w_rr_nxt;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign evt_valid_o   = (r_fill != '0);
  assign evt_data_o    = r_mem[r_rptr];
  assign fill_o        = r_fill;
  assign almost_full_o = (r_fill >= (LOG_DEPTH+1)'(AFULL_TH));
  assign full_o        = w_full;

endmodule

// File: tb/tb_soc_event_arb_fifo.sv
// Directed bench for soc_event_arb_fifo: a round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_soc_event_arb_fifo;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [3:0]  valid;
  logic [31:0] data;
  logic        ready;

  logic [3:0]  ack;
  logic        valid_o;
  logic [7:0]  data_o;
  logic [3:0]  fill;
  logic        afull;
  logic        full;

  logic [3:0]  fx_ack;
  logic        fx_valid_o;
  logic [7:0]  fx_data_o;
  logic [3:0]  fx_fill;
  logic        fx_afull;
  logic        fx_full;

  int n_checks = 0;
  int n_errors = 0;

  soc_event_arb_fifo #(.N_CH(4), .EVNT_WIDTH(8), .LOG_DEPTH(3), .ROUND_ROBIN(1), .AFULL_TH(6))
  u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .evt_valid_i(valid), .evt_data_i(data),
    .evt_ack_o(ack), .evt_valid_o(valid_o), .evt_data_o(data_o), .evt_ready_i(ready),
    .fill_o(fill), .almost_full_o(afull), .full_o(full)
  );

  soc_event_arb_fifo #(.N_CH(4), .EVNT_WIDTH(8), .LOG_DEPTH(3), .ROUND_ROBIN(0), .AFULL_TH(6))
  u_dut_fx (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .evt_valid_i(valid), .evt_data_i(data),
    .evt_ack_o(fx_ack), .evt_valid_o(fx_valid_o), .evt_data_o(fx_data_o), .evt_ready_i(ready),
    .fill_o(fx_fill), .almost_full_o(fx_afull), .full_o(fx_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [7:0] val);
    data[ch*8 +: 8] = val;
  endtask

  logic [7:0]  q[$];
  logic [31:0] ready_pat;
  logic [3:0]  exp_ack;
  int          sent;

  initial begin
    rst_n = 1'b0; clear = 1'b0; valid = '0; data = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ack", 32'(ack), 0);
    check_eq("rst_valid", 32'(valid_o), 0);
    check_eq("rst_data", 32'(data_o), 0);
    check_eq("rst_fill", 32'(fill), 0);
    check_eq("rst_afull", 32'(afull), 0);
    check_eq("rst_full", 32'(full), 0);
    rst_n = 1'b1;

    // T1: single event on ch2, no bypass into an empty FIFO
    @(negedge clk);
    valid = 4'b0100; set_data(2, 8'h5A);
    #1;
    check_eq("t1_ack", 32'(ack), 32'h4);
    check_eq("t1_no_bypass", 32'(valid_o), 0);
    @(negedge clk);
    valid = '0;
    #1;
    check_eq("t1_valid", 32'(valid_o), 1);
    check_eq("t1_data", 32'(data_o), 32'h5A);
    check_eq("t1_fill", 32'(fill), 1);
    check_eq("t1_ack_off", 32'(ack), 0);
    ready = 1'b1;

    // Clear resets rr_ptr so T2 starts from channel 0
    @(negedge clk);
    clear = 1'b1;
    #1;
    check_eq("t1_popped", 32'(fill), 0);
    @(negedge clk);
    clear = 1'b0;

    // T2: round-robin fairness with all channels requesting
    for (int c = 0; c < 4; c++) set_data(c, 8'(8'h10 + c));
    valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check_eq("t2_ack", 32'(ack), 32'(1 << (k % 4)));
      check_eq("t2_fx_ack", 32'(fx_ack), 32'h1);
      if (k > 0) begin
        check_eq("t2_data", 32'(data_o), 32'(8'h10 + ((k - 1) % 4)));
        check_eq("t2_fill", 32'(fill), 1);
      end
    end
    @(negedge clk);
    valid = '0;
    #1;
    check_eq("t2_last", 32'(data_o), 32'h13);

    // T3: ch1 and ch3 requesting; fixed priority starves ch3, RR alternates
    @(negedge clk);
    valid = 4'b1010;
    #1;
    check_eq("t3_fx_ack0", 32'(fx_ack), 32'h2);
    check_eq("t3_rr_ack0", 32'(ack), 32'h2);
    @(negedge clk);
    #1;
    check_eq("t3_fx_ack1", 32'(fx_ack), 32'h2);
    check_eq("t3_rr_ack1", 32'(ack), 32'h8);
    @(negedge clk);
    #1;
    check_eq("t3_fx_ack2", 32'(fx_ack), 32'h2);
    check_eq("t3_rr_ack2", 32'(ack), 32'h2);
    @(negedge clk);
    valid = 4'b1000;
    #1;
    check_eq("t3_fx_ch3", 32'(fx_ack), 32'h8);
    @(negedge clk);
    valid = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("t3_drained", 32'(fill), 0);

    // T4: fill to full with ready low, then pop at full
    ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      valid = 4'b0001; set_data(0, 8'(8'h80 + k));
      #1;
      check_eq("t4_ack", 32'(ack), 1);
      check_eq("t4_fill", 32'(fill), 32'(k));
      check_eq("t4_afull", 32'(afull), 32'(k >= 6));
      check_eq("t4_full", 32'(full), 0);
    end
    @(negedge clk);
    set_data(0, 8'h88); ready = 1'b1;
    #1;
    check_eq("t4_fill8", 32'(fill), 8);
    check_eq("t4_full8", 32'(full), 1);
    check_eq("t4_afull8", 32'(afull), 1);
    check_eq("t4_ack_blk", 32'(ack), 0);
    check_eq("t4_head", 32'(data_o), 32'h80);
    @(negedge clk);
    ready = 1'b0;
    #1;
    check_eq("t4_fill7", 32'(fill), 7);
    check_eq("t4_full7", 32'(full), 0);
    check_eq("t4_ack_free", 32'(ack), 1);
    @(negedge clk);
    valid = '0; ready = 1'b1;
    #1;
    check_eq("t4_refull", 32'(full), 1);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      check_eq("t4_drain_data", 32'(data_o), 32'(8'h81 + j));
      check_eq("t4_drain_fill", 32'(fill), 32'(8 - j));
    end
    @(negedge clk);
    ready = 1'b0;
    #1;
    check_eq("t4_empty", 32'(valid_o), 0);
    check_eq("t4_fill0", 32'(fill), 0);

    // T5: 20 events through ch1 with a fixed irregular ready pattern, scoreboarded
    ready_pat = 32'hF0F0_0C13;
    sent = 0;
    for (int cyc = 0; cyc < 100 && (sent < 20 || q.size() > 0); cyc++) begin
      @(negedge clk);
      valid = (sent < 20) ? 4'b0010 : 4'b0000;
      set_data(1, 8'(8'h20 + sent));
      ready = ready_pat[cyc % 32];
      #1;
      check_eq("t5_fill", 32'(fill), 32'(q.size()));
      check_eq("t5_valid", 32'(valid_o), 32'(q.size() != 0));
      exp_ack = (sent < 20 && q.size() < 8) ? 4'b0010 : 4'b0000;
      check_eq("t5_ack", 32'(ack), 32'(exp_ack));
      if (q.size() != 0 && ready) begin
        check_eq("t5_data", 32'(data_o), 32'(q[0]));
        void'(q.pop_front());
      end
      if (exp_ack != 0) begin
        q.push_back(8'(8'h20 + sent));
        sent++;
      end
    end
    check_eq("t5_done", 32'(sent), 20);
    @(negedge clk);
    valid = '0; ready = 1'b0;
    #1;
    check_eq("t5_empty", 32'(fill), 0);

    // T6: clear with a pending source, then async reset mid-burst
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      valid = 4'b0001; set_data(0, 8'(8'h40 + k));
    end
    @(negedge clk);
    set_data(0, 8'h45); clear = 1'b1;
    #1;
    check_eq("t6_clr_ack", 32'(ack), 0);
    check_eq("t6_fill5", 32'(fill), 5);
    @(negedge clk);
    clear = 1'b0;
    #1;
    check_eq("t6_clr_fill", 32'(fill), 0);
    check_eq("t6_clr_valid", 32'(valid_o), 0);
    check_eq("t6_post_ack", 32'(ack), 1);
    @(negedge clk);
    valid = '0;
    #1;
    check_eq("t6_post_fill", 32'(fill), 1);
    check_eq("t6_post_data", 32'(data_o), 32'h45);
    @(negedge clk);
    valid = 4'b0101; set_data(0, 8'h61); set_data(2, 8'h62);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_ack", 32'(ack), 0);
    check_eq("t6_rst_valid", 32'(valid_o), 0);
    check_eq("t6_rst_data", 32'(data_o), 0);
    check_eq("t6_rst_fill", 32'(fill), 0);
    check_eq("t6_rst_afull", 32'(afull), 0);
    check_eq("t6_rst_full", 32'(full), 0);
    rst_n = 1'b1;
    #1;
    check_eq("t6_rearb", 32'(ack), 1);
    @(negedge clk);
    valid = '0;
    #1;
    check_eq("t6_rearb_fill", 32'(fill), 1);
    check_eq("t6_rearb_data", 32'(data_o), 32'h61);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
